// File: rtl/dma_axi_w.sv
// AXI4 write-burst master: turns DMA databus words into one INCR burst per run,
// then waits for the B response and flags SLVERR/DECERR.
module dma_axi_w #(
    parameter int DMA_DATA_W = 32,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DMA_DATA_W-1:0]   wdata,
    input  logic [DMA_DATA_W/8-1:0] wstrb,
    output logic                    ready,
    input  logic [7:0]              dma_len,
    output logic                    dma_ready,
    output logic                    error,
    output logic                    m_axi_awid,
    output logic [ADDR_W-1:0]       m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic [1:0]              m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DMA_DATA_W-1:0]   m_axi_wdata,
    output logic [DMA_DATA_W/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);
    localparam int         STRB_W = DMA_DATA_W / 8;
    localparam logic [2:0] AWSIZE = 3'($clog2(STRB_W));

    typedef enum logic [1:0] {W_ADDR_HS, W_DATA, W_RESP} state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [7:0]          len_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                awvalid_q;
    logic                dma_ready_q;
    logic                error_q;

    logic beat;
    logic last;
    logic resp_err;

    assign last     = (cnt_q == len_q);
    assign beat     = (state_q == W_DATA) && valid && m_axi_wready;
    assign resp_err = (m_axi_bresp == 2'b10) || (m_axi_bresp == 2'b11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= W_ADDR_HS;
            cnt_q       <= 8'd0;
            len_q       <= 8'd0;
            addr_q      <= '0;
            awvalid_q   <= 1'b0;
            dma_ready_q <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                W_ADDR_HS: begin
                    if (!valid && !awvalid_q) dma_ready_q <= 1'b1;
                    if (awvalid_q) begin
                        if (m_axi_awready) begin
                            awvalid_q <= 1'b0;
                            state_q   <= W_DATA;
                        end
                    end else if (valid) begin
                        addr_q      <= addr;
                        len_q       <= dma_len;
                        awvalid_q   <= 1'b1;
                        dma_ready_q <= 1'b0;
                        error_q     <= 1'b0;
                        cnt_q       <= 8'd0;
                    end
                end
                W_DATA: begin
                    // Hold the counter on the final beat so len=255 never wraps.
                    if (beat) begin
                        if (last) state_q <= W_RESP;
                        else      cnt_q   <= cnt_q + 8'd1;
                    end
                end
                W_RESP: begin
                    if (m_axi_bvalid) begin
                        error_q     <= resp_err;
                        dma_ready_q <= 1'b1;
                        state_q     <= W_ADDR_HS;
                    end
                end
                default: state_q <= W_ADDR_HS;
            endcase
        end
    end

    // Data moves straight through; handshakes are only gated by state.
    assign ready         = (state_q == W_DATA) && m_axi_wready;
    assign m_axi_wvalid  = (state_q == W_DATA) && valid;
    assign m_axi_wlast   = last;
    assign m_axi_wdata   = wdata;
    assign m_axi_wstrb   = wstrb;
    assign m_axi_bready  = (state_q == W_RESP);

    assign dma_ready     = dma_ready_q;
    assign error         = error_q;
    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AWSIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 2'b00;
    assign m_axi_awcache = 4'h2;
    assign m_axi_awprot  = 3'b010;
    assign m_axi_awqos   = 4'h0;
    assign m_axi_awvalid = awvalid_q;
endmodule

// File: tb/tb_dma_axi_w.sv
// Directed bench for dma_axi_w: inputs change 1ns after the rising edge,
// outputs are sampled 1ns later.
module tb_dma_axi_w;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [7:0]  dma_len;
    logic        dma_ready;
    logic        error;
    logic        awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic        awvalid;
    logic        awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_axi_w #(.DMA_DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .ready(ready), .dma_len(dma_len), .dma_ready(dma_ready), .error(error),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present a new run; the AW request becomes visible after the next edge.
    task automatic start_run(input logic [31:0] a, input logic [7:0] l, input logic [31:0] d);
        valid = 1'b1; addr = a; dma_len = l; wdata = d; wstrb = 4'hF;
        settle();
        chk("idle_ready_low", {63'd0, ready}, 64'd0);
        tick();
        chk("awvalid_set", {63'd0, awvalid}, 64'd1);
        chk("awaddr", {32'd0, awaddr}, {32'd0, a});
        chk("awlen", {56'd0, awlen}, {56'd0, l});
        chk("busy", {63'd0, dma_ready}, 64'd0);
    endtask

    // Complete the B phase with the given response, then expect idle.
    task automatic finish_resp(input logic [1:0] r, input logic exp_err);
        chk("bready_resp", {63'd0, bready}, 64'd1);
        chk("wvalid_resp", {63'd0, wvalid}, 64'd0);
        chk("ready_resp", {63'd0, ready}, 64'd0);
        valid = 1'b0; bvalid = 1'b1; bresp = r;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        settle();
        chk("dma_ready_back", {63'd0, dma_ready}, 64'd1);
        chk("bready_off", {63'd0, bready}, 64'd0);
        chk("error_flag", {63'd0, error}, {63'd0, exp_err});
    endtask

    initial begin
        int b;
        int cyc;
        rst = 1'b1; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0; dma_len = '0;
        awready = 1'b1; wready = 1'b1; bresp = 2'b00; bvalid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_dma_ready", {63'd0, dma_ready}, 64'd1);
        chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
        chk("rst_wvalid", {63'd0, wvalid}, 64'd0);
        chk("rst_bready", {63'd0, bready}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_wlast", {63'd0, wlast}, 64'd1);

        // Single beat at 0x100.
        start_run(32'h100, 8'd0, 32'hA1A1_0001);
        chk("awsize", {61'd0, awsize}, 64'd2);
        chk("awburst", {62'd0, awburst}, 64'd1);
        chk("awcache", {60'd0, awcache}, 64'd2);
        chk("awprot", {61'd0, awprot}, 64'd2);
        chk("awid_lock_qos", {55'd0, awid, awlock, awqos}, 64'd0);
        chk("no_w_before_aw", {63'd0, wvalid}, 64'd0);
        tick();
        chk("awvalid_clear", {63'd0, awvalid}, 64'd0);
        chk("single_wvalid", {63'd0, wvalid}, 64'd1);
        chk("single_ready", {63'd0, ready}, 64'd1);
        chk("single_wlast", {63'd0, wlast}, 64'd1);
        chk("single_wdata", {32'd0, m_wdata}, 64'hA1A1_0001);
        chk("single_wstrb", {60'd0, m_wstrb}, 64'hF);
        tick();
        finish_resp(2'b00, 1'b0);

        // Four beats with wready toggling 1,0,1,0,...
        start_run(32'h200, 8'd3, 32'h1000_0000);
        tick();
        b = 0; cyc = 0;
        while (b < 4 && cyc < 20) begin
            wready = (cyc % 2 == 0);
            wdata  = 32'h1000_0000 + b;
            settle();
            chk("tog_ready", {63'd0, ready}, {63'd0, wready});
            chk("tog_wvalid", {63'd0, wvalid}, 64'd1);
            chk("tog_wdata", {32'd0, m_wdata}, {32'd0, 32'h1000_0000 + b});
            chk("tog_wlast", {63'd0, wlast}, {63'd0, (b == 3)});
            if (wready) b++;
            cyc++;
            @(posedge clk); #1;
        end
        chk("tog_beats", 64'(b), 64'd4);
        chk("tog_cycles", 64'(cyc), 64'd7);
        wready = 1'b1;
        settle();
        finish_resp(2'b00, 1'b0);

        // AW stalled five cycles.
        awready = 1'b0;
        start_run(32'h300, 8'd1, 32'h3000_0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_awvalid", {63'd0, awvalid}, 64'd1);
            chk("stall_awaddr", {32'd0, awaddr}, 64'h300);
            chk("stall_awlen", {56'd0, awlen}, 64'd1);
            chk("stall_wvalid", {62'd0, wvalid, ready}, 64'd0);
        end
        awready = 1'b1;
        tick();
        chk("post_aw_wvalid", {63'd0, wvalid}, 64'd1);
        chk("post_aw_awvalid", {63'd0, awvalid}, 64'd0);
        chk("stall_b0_wlast", {63'd0, wlast}, 64'd0);
        tick();
        wdata = 32'h3000_0001;
        settle();
        chk("stall_b1_wlast", {63'd0, wlast}, 64'd1);
        chk("stall_b1_wdata", {32'd0, m_wdata}, 64'h3000_0001);
        tick();
        finish_resp(2'b00, 1'b0);

        // SLVERR on one burst, OKAY on the next.
        start_run(32'h400, 8'd0, 32'h4);
        tick(); tick();
        finish_resp(2'b10, 1'b1);
        tick(); tick();
        chk("error_held", {63'd0, error}, 64'd1);
        valid = 1'b1; addr = 32'h500; dma_len = 8'd0;
        settle();
        chk("error_until_aw", {63'd0, error}, 64'd1);
        tick();
        chk("error_cleared_aw", {63'd0, error}, 64'd0);
        tick(); tick();
        finish_resp(2'b00, 1'b0);

        // 256-beat burst.
        start_run(32'h1000, 8'd255, 32'h0);
        tick();
        b = 0; cyc = 0;
        while (b < 256 && cyc < 400) begin
            wdata = 32'hB000_0000 + b;
            settle();
            chk("long_wlast", {63'd0, wlast}, {63'd0, (b == 255)});
            chk("long_ready", {63'd0, ready}, 64'd1);
            b++; cyc++;
            @(posedge clk); #1;
        end
        chk("long_beats", 64'(b), 64'd256);
        finish_resp(2'b00, 1'b0);

        // Asynchronous reset in the middle of a data phase.
        start_run(32'h600, 8'd3, 32'h6);
        tick(); tick();
        chk("pre_rst_wvalid", {63'd0, wvalid}, 64'd1);
        rst = 1'b1;
        settle();
        chk("mid_rst_dma_ready", {63'd0, dma_ready}, 64'd1);
        chk("mid_rst_awvalid", {63'd0, awvalid}, 64'd0);
        chk("mid_rst_wvalid", {63'd0, wvalid}, 64'd0);
        chk("mid_rst_bready", {63'd0, bready}, 64'd0);
        chk("mid_rst_error", {63'd0, error}, 64'd0);
        valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("after_rst_awvalid", {63'd0, awvalid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
